// File: rtl/axis_tg_lfsr.sv
// axis_tg_lfsr -- AXI-Stream NoC traffic generator (transmit side of an endpoint).
//
// Injects single-flit packets at a programmable load to LFSR-chosen
// destinations. Each flit carries the injection timestamp in the upper half of
// tdata and a per-destination sequence number in the lower half.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load                injection probability x65535 (inject when inj LFSR < load)
//   num_packets         packets to send, latched on IDLE->RUN
//   start               level, begins a run
//   ticks               free-running timestamp
//   done                sticky run-complete flag
//   sent_packets[]      handshaken flits per destination
//   total_sent_packets  handshaken flits, all destinations
//   axis_out_*          AXI-Stream master
//
// Build option: define AXIS_TG_SKIP_SELF_EN to redirect self-addressed flits
// (dest == TID) to (TID+1) % NUM_ROUTERS.
module axis_tg_lfsr #(
  parameter int SEED        = 1,
  parameter int COUNT_WIDTH = 32,
  parameter int TID         = 0,
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2,
  parameter int NUM_ROUTERS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              load,
  input  logic [COUNT_WIDTH-1:0]   num_packets,
  input  logic                     start,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   sent_packets [NUM_ROUTERS],
  output logic [COUNT_WIDTH-1:0]   total_sent_packets,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest
);

  localparam int          HALF     = TDATA_WIDTH / 2;
  localparam logic [15:0] POLY     = 16'hB400;
  localparam logic [15:0] INJ_SEED = (16'(SEED) == 16'h0) ? 16'hACE1 : 16'(SEED);
  localparam logic [15:0] DST_MIX  = {INJ_SEED[7:0], INJ_SEED[15:8]} ^ 16'h5A5A;
  localparam logic [15:0] DST_SEED = (DST_MIX == 16'h0) ? 16'h0001 : DST_MIX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? POLY : 16'h0);
  endfunction

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   num_q, num_d;
  logic [COUNT_WIDTH-1:0]   gen_cnt_q, gen_cnt_d;
  logic [COUNT_WIDTH-1:0]   total_q, total_d;
  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0]   cnt_d [NUM_ROUTERS];
  logic [15:0]              inj_q, inj_d, dst_q, dst_d;
  logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
  logic [TDEST_WIDTH-1:0]   dest;
  logic                     hs, gen;

  // Destination from the current dst LFSR: (dst * NUM_ROUTERS) >> 16.
  always_comb begin
    dest = TDEST_WIDTH'((32'(dst_q) * NUM_ROUTERS) >> 16);
`ifdef AXIS_TG_SKIP_SELF_EN
    if (dest == TDEST_WIDTH'(TID)) dest = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);
`endif
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    gen_cnt_d = gen_cnt_q;
    inj_d     = inj_q;
    dst_d     = dst_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tdest_d   = tdest_q;
    tlast_d   = tlast_q;
    gen       = 1'b0;
    hs        = tvalid_q && axis_out_tready;
    total_d   = total_q + COUNT_WIDTH'(hs);
    for (int i = 0; i < NUM_ROUTERS; i++)
      cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(hs && (tdest_q == TDEST_WIDTH'(i)));

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        num_d   = num_packets;
      end
      S_RUN: begin
        inj_d = lfsr_next(inj_q);
        gen   = (!tvalid_q || hs) && (gen_cnt_q < num_q) && (inj_q < load);
        if (hs) tvalid_d = 1'b0;
        if (gen) begin
          // Sequence number includes a handshake landing on this same edge, so
          // back-to-back flits to one destination still count 0,1,2,...
          tvalid_d  = 1'b1;
          tdata_d   = {ticks, HALF'(cnt_d[dest])};
          tdest_d   = dest;
          tlast_d   = 1'b1;
          dst_d     = lfsr_next(dst_q);
          gen_cnt_d = gen_cnt_q + COUNT_WIDTH'(1);
        end
        if ((num_q == '0) || (hs && (total_d == num_q))) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      gen_cnt_q <= '0;
      total_q   <= '0;
      cnt_q     <= '{default: '0};
      inj_q     <= INJ_SEED;
      dst_q     <= DST_SEED;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tdest_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      gen_cnt_q <= gen_cnt_d;
      total_q   <= total_d;
      cnt_q     <= cnt_d;
      inj_q     <= inj_d;
      dst_q     <= dst_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tdest_q   <= tdest_d;
      tlast_q   <= tlast_d;
    end
  end

  assign done               = (state_q == S_DONE);
  assign sent_packets       = cnt_q;
  assign total_sent_packets = total_q;
  assign axis_out_tvalid    = tvalid_q;
  assign axis_out_tdata     = tdata_q;
  assign axis_out_tlast     = tlast_q;
  assign axis_out_tdest     = tdest_q;
  assign axis_out_tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg_lfsr.sv
module tb_axis_tg_lfsr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] load = '0;
  logic [31:0] num_packets = '0;
  logic        start = 1'b0;
  logic [31:0] ticks = 32'h1000_0000;
  logic        done;
  logic [31:0] sent [4];
  logic [31:0] total;
  logic        tvalid, tready = 1'b0, tlast;
  logic [63:0] tdata;
  logic [1:0]  tid, tdest;

  axis_tg_lfsr #(.SEED(1), .COUNT_WIDTH(32), .TID(2), .TDATA_WIDTH(64),
                 .TDEST_WIDTH(2), .TID_WIDTH(2), .NUM_ROUTERS(4)) dut (
    .clk(clk), .rst(rst), .load(load), .num_packets(num_packets), .start(start),
    .ticks(ticks), .done(done), .sent_packets(sent), .total_sent_packets(total),
    .axis_out_tvalid(tvalid), .axis_out_tready(tready), .axis_out_tdata(tdata),
    .axis_out_tlast(tlast), .axis_out_tid(tid), .axis_out_tdest(tdest));

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] dest; logic [31:0] seq; } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m_dst;
  int          m_cnt [4];
  logic [31:0] prev_ticks = '0;
  bit          fresh_seen = 0;
  int          self_hits = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic model_reset();
    logic [15:0] s;
    s = 16'h0001;
    m_dst = {s[7:0], s[15:8]} ^ 16'h5A5A;
    if (m_dst == 16'h0) m_dst = 16'h0001;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sb.delete();
    fresh_seen = 0;
  endtask

  // Expected flit order for a run of n packets.
  task automatic push_run(input int n);
    for (int k = 0; k < n; k++) begin
      int d;
      d = int'((32'(m_dst) * 32'd4) >> 16);
`ifdef AXIS_TG_SKIP_SELF_EN
      if (d == 2) d = 3;
`endif
      sb.push_back('{dest: 2'(d), seq: 32'(m_cnt[d])});
      m_cnt[d]++;
      m_dst = lfsr(m_dst);
    end
  endtask

  // Check the visible flit, then advance one clock; sampling sits 1ns after the edge.
  task automatic cycle();
    exp_t e;
    if (tvalid && !fresh_seen) begin
      chk("tick_stamp", {32'h0, tdata[63:32]}, {32'h0, prev_ticks});
      fresh_seen = 1;
    end
    if (tvalid && tready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("flit_tdest", 64'(tdest), 64'(e.dest));
        chk("flit_seq", 64'(tdata[31:0]), 64'(e.seq));
        chk("flit_tlast", 64'(tlast), 64'd1);
        chk("flit_tid", 64'(tid), 64'd2);
      end
      if (tdest == 2'd2) self_hits++;
      fresh_seen = 0;
    end
    prev_ticks = ticks;
    @(posedge clk); #1;
    ticks = ticks + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; tready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_until(input int n, input int budget, input bit rnd);
    int c;
    c = 0;
    while (total != 32'(n) && c < budget) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      c++;
    end
    chk("run_total", 64'(total), 64'(n));
    chk("done_same_edge", 64'(done), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int seen, sum;
    logic [63:0] held_data;
    logic [1:0]  held_dest;

    // Reset values
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdest", 64'(tdest), 64'd0);
    chk("rst_tid", 64'(tid), 64'd2);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    do_reset();

    // Full load, 8 packets, always ready
    load = 16'hFFFF; num_packets = 32'd8; start = 1'b1;
    push_run(8);
    run_until(8, 200, 0);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      chk("per_dest_count", 64'(sent[i]), 64'(m_cnt[i]));
      sum += int'(sent[i]);
    end
    chk("sum_sent", 64'(sum), 64'd8);
    seen = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (tvalid) seen++; end
    chk("no_tvalid_after_done", 64'(seen), 64'd0);
    chk("done_sticky", 64'(done), 64'd1);

    // Zero-packet run: done one cycle after IDLE->RUN
    do_reset();
    load = 16'hFFFF; num_packets = 32'd0; start = 1'b1;
    cycle();
    chk("zero_done_not_yet", 64'(done), 64'd0);
    cycle();
    chk("zero_done", 64'(done), 64'd1);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (tvalid) seen++; end
    chk("zero_no_flits", 64'(seen), 64'd0);
    chk("zero_total", 64'(total), 64'd0);

    // Load 0: never injects
    do_reset();
    load = 16'h0; num_packets = 32'd8; start = 1'b1; tready = 1'b1;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin cycle(); if (tvalid) seen++; end
    chk("load0_no_tvalid", 64'(seen), 64'd0);
    chk("load0_done", 64'(done), 64'd0);
    chk("load0_total", 64'(total), 64'd0);

    // Backpressure: flit held stable, counters frozen
    do_reset();
    load = 16'hFFFF; num_packets = 32'd4; start = 1'b1; tready = 1'b0;
    push_run(4);
    seen = 0;
    while (!tvalid && seen < 20) begin cycle(); seen++; end
    chk("stall_tvalid", 64'(tvalid), 64'd1);
    held_data = tdata; held_dest = tdest;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_tvalid_held", 64'(tvalid), 64'd1);
      chk("stall_tdata", tdata, held_data);
      chk("stall_tdest", 64'(tdest), 64'(held_dest));
      chk("stall_total", 64'(total), 64'd0);
    end
    tready = 1'b1;
    cycle();
    tready = 1'b0;
    chk("one_increment", 64'(total), 64'd1);
    cycle(); cycle();
    chk("still_one", 64'(total), 64'd1);
    run_until(4, 100, 0);

    // Self-addressed destinations, random backpressure
    do_reset();
    self_hits = 0;
    load = 16'hFFFF; num_packets = 32'd1000; start = 1'b1;
    push_run(1000);
    run_until(1000, 8000, 1);
`ifdef AXIS_TG_SKIP_SELF_EN
    chk("no_self_dest", 64'(self_hits), 64'd0);
`else
    chk("self_dest_seen", 64'(self_hits > 0), 64'd1);
`endif

    // Reset mid-run with a pending flit, then restart
    do_reset();
    load = 16'hFFFF; num_packets = 32'd20; start = 1'b1; tready = 1'b0;
    push_run(20);
    seen = 0;
    while (!tvalid && seen < 20) begin cycle(); seen++; end
    tready = 1'b1;
    cycle(); cycle();
    chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_tdata", tdata, 64'd0);
    chk("midrst_tdest", 64'(tdest), 64'd0);
    chk("midrst_tlast", 64'(tlast), 64'd0);
    chk("midrst_total", 64'(total), 64'd0);
    chk("midrst_sent0", 64'(sent[0] | sent[1] | sent[2] | sent[3]), 64'd0);
    num_packets = 32'd12;
    #1;
    rst = 1'b0;
    model_reset();
    push_run(12);
    run_until(12, 200, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
